bus_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the shared processor bus (BUS_DATA/BUS_ADDR/BUS_WE), peer of LEDs/SevenSeg/Timer.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/bus_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the bus UART transmitter: register offsets, serialiser
// states and status-register layout.
package uart_pkg;

  localparam logic [7:0] REG_DATA = 8'd0;
  localparam logic [7:0] REG_STAT = 8'd1;
  localparam logic [7:0] REG_CTRL = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  function automatic logic [7:0] pack_status(
    input logic ovf,
    input logic busy,
    input logic full,
    input logic empty
  );
    logic [7:0] stat;
    stat             = 8'h00;
    stat[STAT_OVF]   = ovf;
    stat[STAT_BUSY]  = busy;
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    return stat;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with one extra pointer bit for full/empty detection.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags and accepted push/pop from the registered pointers.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    dout      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer registers; they wrap through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register window, TX FIFO, serialiser
// and TX-empty interrupt.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hE0,
  parameter int         BAUD_DIV   = 868,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic       TX_OUT
);
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  tx_state_e   state_r;
  tx_state_e   state_nx_s;
  logic [15:0] baud_r;
  logic [15:0] baud_nx_s;
  logic [2:0]  bit_r;
  logic [2:0]  bit_nx_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_nx_s;
  logic        tx_r;
  logic        tx_nx_s;
  logic        pop_s;
  logic        busy_s;
  logic        stop_done_s;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [7:0]  fifo_dout_s;

  logic        sel_data_s;
  logic        sel_stat_s;
  logic        sel_ctrl_s;
  logic        push_s;
  logic        ctrl_wr_s;
  logic        rd_hit_s;
  logic        ovf_set_s;
  logic        irq_set_s;
  logic [7:0]  rd_val_s;

  logic        irq_en_r;
  logic        raise_r;
  logic        ovf_r;
  logic        rd_en_r;
  logic [7:0]  rd_data_r;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push_s),
    .pop   (pop_s),
    .din   (BUS_DATA),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .dout  (fifo_dout_s)
  );

  // Address decode, write strobes and read-data mux.
  always_comb begin
    sel_data_s  = (BUS_ADDR == BASE_ADDR + REG_DATA);
    sel_stat_s  = (BUS_ADDR == BASE_ADDR + REG_STAT);
    sel_ctrl_s  = (BUS_ADDR == BASE_ADDR + REG_CTRL);
    push_s      = BUS_WE && sel_data_s;
    ctrl_wr_s   = BUS_WE && sel_ctrl_s;
    rd_hit_s    = !BUS_WE && (sel_data_s || sel_stat_s || sel_ctrl_s);
    busy_s      = (state_r != ST_IDLE);
    ovf_set_s   = push_s && fifo_full_s && !pop_s;
    stop_done_s = (state_r == ST_STOP) && (baud_r == 16'd0);
    irq_set_s   = stop_done_s && fifo_empty_s && irq_en_r;
    if (sel_stat_s) begin
      rd_val_s = pack_status(ovf_r, busy_s, fifo_full_s, fifo_empty_s);
    end else if (sel_ctrl_s) begin
      rd_val_s = {7'b0000000, irq_en_r};
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // Serialiser next-state: one baud period per start, data and stop bit.
  always_comb begin
    state_nx_s = state_r;
    baud_nx_s  = baud_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_nx_s = fifo_dout_s;
          baud_nx_s  = BAUD_RELOAD;
          state_nx_s = ST_START;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_START: begin
        if (baud_r == 16'd0) begin
          baud_nx_s  = BAUD_RELOAD;
          bit_nx_s   = 3'd0;
          state_nx_s = ST_DATA;
        end else begin
          baud_nx_s = baud_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_r == 16'd0) begin
          baud_nx_s = BAUD_RELOAD;
          if (bit_r == 3'd7) begin
            state_nx_s = ST_STOP;
          end else begin
            bit_nx_s   = bit_r + 3'd1;
            shift_nx_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_nx_s = baud_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_r == 16'd0) begin
          baud_nx_s  = BAUD_RELOAD;
          state_nx_s = ST_IDLE;
        end else begin
          baud_nx_s = baud_r - 16'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    // Line level is registered from the next state so TX_OUT tracks the FSM without lag.
    case (state_nx_s)
      ST_START: tx_nx_s = 1'b0;
      ST_DATA:  tx_nx_s = shift_nx_s[0];
      default:  tx_nx_s = 1'b1;
    endcase
  end

  // Serialiser state, baud counter, shifter and line register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      baud_r  <= baud_nx_s;
      bit_r   <= bit_nx_s;
      shift_r <= shift_nx_s;
      tx_r    <= tx_nx_s;
    end
  end

  // Control, sticky overflow, interrupt and registered read data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_en_r  <= 1'b0;
      raise_r   <= 1'b0;
      ovf_r     <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_data_r <= 8'h00;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_r <= BUS_DATA[0];
      end
      if (irq_set_s) begin
        raise_r <= 1'b1;
      end else if (ctrl_wr_s && !BUS_DATA[0]) begin
        raise_r <= 1'b0;
      end else if (BUS_INTERRUPT_ACK) begin
        raise_r <= 1'b0;
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (rd_hit_s && sel_stat_s) begin
        ovf_r <= 1'b0;
      end
      rd_en_r   <= rd_hit_s;
      rd_data_r <= rd_hit_s ? rd_val_s : 8'h00;
    end
  end

  // The bus is released whenever the processor writes, even right after a read.
  assign BUS_DATA            = (rd_en_r && !BUS_WE) ? rd_data_r : 8'bzzzz_zzzz;
  assign TX_OUT              = tx_r;
  assign BUS_INTERRUPT_RAISE = raise_r;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register table, directed frame/FIFO/IRQ/reset
// sequences and randomized bus traffic against a frame-level reference model.
module tb_bus_uart_tx;
  localparam logic [7:0] BASE  = 8'hE0;
  localparam int         BAUD  = 4;
  localparam int         DEPTH = 8;
  localparam int         FRAME = 10 * BAUD;
  localparam logic [7:0] FLOAT = 8'hFF;  // bus is pulled up when nobody drives it

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       we    = 1'b0;
  logic       drv   = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] wdata = 8'h00;
  wire  [7:0] bus_data;
  wire        raise;
  wire        tx;

  int errors = 0;
  int checks = 0;

  assign bus_data = drv ? wdata : 8'bzzzz_zzzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (bus_data[g]);
  end

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (addr),
    .BUS_WE              (we),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack),
    .TX_OUT              (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue + frame timing arithmetic) ----------------
  logic [7:0] q[$];
  int         edge_n    = 0;
  int         free_edge = 0;      // first edge at which the engine may start a new frame
  int         pop_edge  = -1000;  // edge at which the current frame's byte left the FIFO
  logic [7:0] cur       = 8'h00;
  bit         m_ovf     = 1'b0;
  bit         m_irqen   = 1'b0;
  bit         m_raise   = 1'b0;
  bit         exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;

  initial forever begin : model
    int e;
    bit empty_b, full_b, busy_b, do_pop, push, ovf_set, set_irq, rd_hit;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      edge_n = 0; free_edge = 0; pop_edge = -1000; cur = 8'h00;
      m_ovf = 1'b0; m_irqen = 1'b0; m_raise = 1'b0; exp_valid = 1'b0; exp_data = 8'h00;
    end else begin
      e       = edge_n;
      empty_b = (q.size() == 0);
      full_b  = (q.size() == DEPTH);
      busy_b  = (e < free_edge);
      do_pop  = !busy_b && !empty_b;
      set_irq = (e == free_edge - 1) && empty_b && m_irqen;
      rd_hit  = !we && (addr == BASE || addr == BASE + 8'd1 || addr == BASE + 8'd2);
      exp_valid = rd_hit;
      if (addr == BASE + 8'd1) exp_data = {4'b0000, m_ovf, busy_b, full_b, empty_b};
      else if (addr == BASE + 8'd2) exp_data = {7'b0000000, m_irqen};
      else exp_data = 8'h00;
      push    = we && (addr == BASE);
      ovf_set = push && full_b && !do_pop;
      if (do_pop) begin
        cur = q.pop_front();
        pop_edge = e;
        free_edge = e + FRAME + 1;
      end
      if (push && !ovf_set) q.push_back(wdata);
      if (ovf_set) m_ovf = 1'b1;
      else if (rd_hit && addr == BASE + 8'd1) m_ovf = 1'b0;
      if (set_irq) m_raise = 1'b1;
      else if (we && addr == BASE + 8'd2 && !wdata[0]) m_raise = 1'b0;
      else if (ack) m_raise = 1'b0;
      if (we && addr == BASE + 8'd2) m_irqen = wdata[0];
      edge_n = e + 1;
    end
  end

  function automatic logic model_tx();
    int off;
    logic [9:0] fr;
    off = edge_n - 1 - pop_edge;
    fr  = {1'b1, cur, 1'b0};
    if (off >= 0 && off < FRAME) return fr[off / BAUD];
    return 1'b1;
  endfunction

  // Continuous comparison of line, interrupt and bus against the model.
  initial forever begin : checker_loop
    @(negedge clk);
    chk("tx_line", {7'b0000000, tx}, {7'b0000000, model_tx()});
    chk("irq_raise", {7'b0000000, raise}, {7'b0000000, m_raise});
    if (exp_valid && !we) chk("bus_read", bus_data, exp_data);
    else if (!drv) chk("bus_float", bus_data, FLOAT);
  end

  // Independent line receiver: decodes frames at bit centres.
  logic [7:0] rx_q[$];
  initial forever begin : rx_mon
    logic [7:0] rx_b;
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      repeat (6) @(negedge clk);
      rx_b[0] = tx;
      for (int k = 1; k < 8; k++) begin
        repeat (BAUD) @(negedge clk);
        rx_b[k] = tx;
      end
      repeat (BAUD) @(negedge clk);
      if (tx === 1'b1) rx_q.push_back(rx_b);
      @(negedge clk);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 1'b0; drv = 1'b0; addr = 8'h00; wdata = 8'h00;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; drv = 1'b1; addr = a; wdata = d;
    tick();
    idle_in();
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    we = 1'b0; drv = 1'b0; addr = a;
    tick();
    addr = 8'h00;
    @(negedge clk);
    d = bus_data;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || edge_n < free_edge) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected below 3000", n);
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    vec_t       tbl[12];
    logic [7:0] d;
    logic [9:0] frame;
    logic [7:0] exp_bytes[$];
    int         n;
    int         r;

    idle_in();
    repeat (3) tick();
    chk("reset_tx", {7'b0000000, tx}, 8'h01);
    chk("reset_raise", {7'b0000000, raise}, 8'h00);
    chk("reset_bus", bus_data, FLOAT);
    rst_n = 1'b1;
    tick();

    // Register map table.
    tbl[0]  = '{1'b0, 8'hE1, 8'h00, 8'h01};
    tbl[1]  = '{1'b0, 8'hE2, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'hE0, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'hE3, 8'h00, FLOAT};
    tbl[4]  = '{1'b1, 8'hE2, 8'hFF, 8'h00};
    tbl[5]  = '{1'b0, 8'hE2, 8'h00, 8'h01};
    tbl[6]  = '{1'b1, 8'hE1, 8'h55, 8'h00};
    tbl[7]  = '{1'b0, 8'hE1, 8'h00, 8'h01};
    tbl[8]  = '{1'b1, 8'hE2, 8'hFE, 8'h00};
    tbl[9]  = '{1'b0, 8'hE2, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 8'hDF, 8'h00, FLOAT};
    tbl[11] = '{1'b0, 8'h00, 8'h00, FLOAT};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) begin
        bus_wr(tbl[i].addr, tbl[i].data);
      end else begin
        bus_rd(tbl[i].addr, d);
        chk("tbl_read", d, tbl[i].exp);
      end
    end

    // Single 8'hA5 frame, bit by bit.
    bus_wr(BASE, 8'hA5);
    tick();
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < BAUD; j++) begin
        @(negedge clk);
        chk("a5_bit", {7'b0000000, tx}, {7'b0000000, frame[k]});
      end
    end
    wait_drain();

    // Fill the FIFO back-to-back, then overflow it.
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; drv = 1'b1; addr = BASE; wdata = 8'h10 + 8'(i);
      tick();
    end
    idle_in();
    bus_rd(BASE + 8'd1, d); chk("stat_full", d, 8'h06);
    bus_wr(BASE, 8'h99);
    bus_rd(BASE + 8'd1, d); chk("stat_ovf", d, 8'h0E);
    bus_rd(BASE + 8'd1, d); chk("stat_ovf_clr", d, 8'h06);
    wait_drain();

    // Interrupt at end of STOP, then ACK.
    bus_wr(BASE + 8'd2, 8'h01);
    bus_wr(BASE, 8'h3C);
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      chk("irq_early", {7'b0000000, raise}, 8'h00);
    end
    @(negedge clk);
    chk("irq_set", {7'b0000000, raise}, 8'h01);
    repeat (3) tick();
    chk("irq_hold", {7'b0000000, raise}, 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    @(negedge clk);
    chk("irq_ack", {7'b0000000, raise}, 8'h00);
    bus_wr(BASE, 8'h5A);
    wait_drain();
    @(negedge clk);
    chk("irq_set2", {7'b0000000, raise}, 8'h01);
    bus_wr(BASE + 8'd2, 8'h00);
    @(negedge clk);
    chk("irq_en_clr", {7'b0000000, raise}, 8'h00);
    bus_wr(BASE, 8'hC3);
    wait_drain();
    repeat (5) tick();
    chk("irq_disabled", {7'b0000000, raise}, 8'h00);

    // Reset during data bit 3.
    bus_wr(BASE, 8'hF0);
    tick();
    repeat (17) @(negedge clk);
    chk("pre_reset_bit3", {7'b0000000, tx}, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_tx", {7'b0000000, tx}, 8'h01);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    bus_rd(BASE + 8'd1, d); chk("stat_after_reset", d, 8'h01);
    repeat (60) tick();
    chk("no_residual", {7'b0000000, tx}, 8'h01);

    // Tristate timing: driven only the cycle after a read, never while writing.
    we = 1'b0; addr = BASE + 8'd1; tick(); addr = 8'h00;
    @(negedge clk); chk("tri_drive", bus_data, 8'h01);
    tick();
    @(negedge clk); chk("tri_release", bus_data, FLOAT);
    we = 1'b0; addr = BASE + 8'd1; tick();
    we = 1'b1; drv = 1'b0; addr = 8'h10;
    @(negedge clk); chk("tri_we", bus_data, FLOAT);
    tick();
    idle_in();

    // Full FIFO with a push on the pop cycle between frames.
    rx_q.delete();
    exp_bytes.delete();
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; drv = 1'b1; addr = BASE; wdata = 8'h30 + 8'(i);
      exp_bytes.push_back(wdata);
      tick();
    end
    idle_in();
    n = 0;
    while (edge_n != free_edge && n < 200) begin
      tick();
      n++;
    end
    chk("pop_cycle_found", 8'(n < 200), 8'h01);
    we = 1'b1; drv = 1'b1; addr = BASE; wdata = 8'h77;
    exp_bytes.push_back(wdata);
    tick();
    idle_in();
    bus_rd(BASE + 8'd1, d); chk("stat_push_on_pop", d, 8'h06);
    wait_drain();
    repeat (3) tick();
    chk("rx_count", 8'(rx_q.size()), 8'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++) begin
      if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp_bytes[i]);
    end

    // Randomized bus traffic, dense then sparse writes.
    for (int i = 0; i < 2000; i++) begin
      idle_in();
      ack = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < ((i < 1000) ? 10 : 2)) begin
        we = 1'b1; drv = 1'b1; addr = BASE; wdata = 8'($urandom);
      end else if (r < 30) begin
        addr = BASE + 8'd1;
      end else if (r < 36) begin
        addr = BASE + 8'd2;
      end else if (r < 39) begin
        addr = BASE;
      end else if (r < 43) begin
        addr = 8'($urandom);
      end else if (r < 47) begin
        we = 1'b1; drv = 1'b1; addr = BASE + 8'd2; wdata = 8'($urandom);
      end else if (r < 50) begin
        we = 1'b1; drv = 1'b1; addr = 8'($urandom); wdata = 8'($urandom);
      end else if (r < 56) begin
        ack = 1'b1;
      end
      tick();
    end
    idle_in();
    ack = 1'b0;
    wait_drain();
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
